// File: rtl/ibex_sram_arbiter.sv
// ibex_sram_arbiter
// N-host req/gnt/rvalid/err arbiter and address decoder in front of a single
// single-port SRAM with a 1-cycle read latency. Every grant gets exactly one
// response one cycle later. Accesses outside the SRAM window get an error
// response and never reach the SRAM.
//
// Build option: define IBEX_SRAM_ARB_ROUND_ROBIN_EN to get round-robin
// arbitration with a rotating priority pointer. Without it, the lowest-index
// requesting host always wins and no pointer register is built.

module ibex_sram_arbiter #(
  parameter int unsigned NumHosts = 2,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MemSize  = 65536,
  parameter int unsigned AddrW    = $clog2(MemSize / 4)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [NumHosts-1:0]   host_req_i,
  output logic [NumHosts-1:0]   host_gnt_o,
  output logic [NumHosts-1:0]   host_rvalid_o,
  output logic [NumHosts-1:0]   host_err_o,
  input  logic [NumHosts-1:0]   host_we_i,
  input  logic [4*NumHosts-1:0] host_be_i,
  input  logic [32*NumHosts-1:0] host_addr_i,
  input  logic [32*NumHosts-1:0] host_wdata_i,
  output logic [31:0]           host_rdata_o,

  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [AddrW-1:0]      ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned IdxW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam logic [31:0] WinMask = ~(32'(MemSize) - 32'd1);

  logic            gnt_valid;
  logic [IdxW-1:0] gnt_idx;

  logic            sel_we;
  logic [3:0]      sel_be;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_in_win;

  logic            resp_valid_q;
  logic [IdxW-1:0] resp_idx_q;
  logic            resp_err_q;
  logic            resp_rd_q;
  logic            resp_live;

`ifdef IBEX_SRAM_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;

  // Pick the first requester at or after the pointer, wrapping modulo NumHosts.
  always_comb begin : grant_select
    logic [IdxW:0]   cand_sum;
    logic [IdxW-1:0] cand_idx;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      cand_sum = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand_sum >= (IdxW+1)'(NumHosts)) cand_sum = cand_sum - (IdxW+1)'(NumHosts);
      cand_idx = cand_sum[IdxW-1:0];
      if (!gnt_valid && host_req_i[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    // Nothing is granted while reset is held.
    if (rst_i) gnt_valid = 1'b0;
  end

  // Advance the priority pointer past the host just granted; hold it otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_valid) begin
      ptr_q <= (gnt_idx == IdxW'(NumHosts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  // Fixed priority: scan downwards so the lowest-index requester is the last
  // (and therefore winning) assignment.
  always_comb begin : grant_select
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      if (host_req_i[IdxW'(i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
    // Nothing is granted while reset is held.
    if (rst_i) gnt_valid = 1'b0;
  end
`endif

  // Mux the granted host's request fields and decode the SRAM window.
  assign sel_we     = host_we_i[gnt_idx];
  assign sel_be     = host_be_i[{gnt_idx, 2'b00} +: 4];
  assign sel_addr   = host_addr_i[{gnt_idx, 5'b00000} +: 32];
  assign sel_wdata  = host_wdata_i[{gnt_idx, 5'b00000} +: 32];
  assign sel_in_win = (sel_addr & WinMask) == MemStart;

  assign host_gnt_o = gnt_valid ? (NumHosts'(1) << gnt_idx) : '0;

  // Drive the SRAM port from the granted host; everything idles at zero.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt_valid) begin
      ram_req_o   = sel_in_win;
      ram_we_o    = sel_we & sel_in_win;
      ram_be_o    = sel_be;
      ram_addr_o  = sel_addr[AddrW+1:2];
      ram_wdata_o = sel_wdata;
    end
  end

  // Response stage: remember who was granted and how the access must complete.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      resp_valid_q <= gnt_valid;
      resp_idx_q   <= gnt_idx;
      resp_err_q   <= gnt_valid & ~sel_in_win;
      resp_rd_q    <= gnt_valid & sel_in_win & ~sel_we;
    end
  end

  // A response still in the register when reset arrives is suppressed.
  assign resp_live     = resp_valid_q & ~rst_i;
  assign host_rvalid_o = resp_live ? (NumHosts'(1) << resp_idx_q) : '0;
  assign host_err_o    = (resp_live & resp_err_q) ? (NumHosts'(1) << resp_idx_q) : '0;
  assign host_rdata_o  = (resp_live & resp_rd_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Directed testbench for ibex_sram_arbiter (two hosts, 64 kB window at 0).
// A small behavioural SRAM answers reads one cycle after ram_req_o.
// Expected grant order follows IBEX_SRAM_ARB_ROUND_ROBIN_EN when defined.

module tb_ibex_sram_arbiter;

  localparam int NH = 2;
  localparam int AW = 14;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NH-1:0]  host_req_i;
  logic [NH-1:0]  host_gnt_o;
  logic [NH-1:0]  host_rvalid_o;
  logic [NH-1:0]  host_err_o;
  logic [NH-1:0]  host_we_i;
  logic [4*NH-1:0]  host_be_i;
  logic [32*NH-1:0] host_addr_i;
  logic [32*NH-1:0] host_wdata_i;
  logic [31:0]    host_rdata_o;
  logic           ram_req_o;
  logic           ram_we_o;
  logic [3:0]     ram_be_o;
  logic [AW-1:0]  ram_addr_o;
  logic [31:0]    ram_wdata_o;
  logic [31:0]    ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  ibex_sram_arbiter #(
    .NumHosts (NH),
    .MemStart (32'h0000_0000),
    .MemSize  (65536)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_rvalid_o (host_rvalid_o),
    .host_err_o    (host_err_o),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_addr_i   (host_addr_i),
    .host_wdata_i  (host_wdata_i),
    .host_rdata_o  (host_rdata_o),
    .ram_req_o     (ram_req_o),
    .ram_we_o      (ram_we_o),
    .ram_be_o      (ram_be_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural 16-word SRAM, reloaded with known contents during reset.
  logic [31:0] mem [16];
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'hA0A0_0000;
      mem[1]    <= 32'hB1B1_0004;
      mem[2]    <= 32'hC2C2_0008;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[8]    <= 32'h1122_3344;
      ram_rdata <= 32'h0;
    end else if (ram_req_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[3:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr_o[3:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    host_req_i   = '0;
    host_we_i    = '0;
    host_be_i    = '0;
    host_addr_i  = '0;
    host_wdata_i = '0;
  endtask

  task automatic set_host(input int k, input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    host_req_i[k]            = req;
    host_we_i[k]             = we;
    host_be_i[4*k +: 4]      = be;
    host_addr_i[32*k +: 32]  = addr;
    host_wdata_i[32*k +: 32] = wdata;
  endtask

  logic [1:0]  prev_rv;
  logic [31:0] prev_rd;
  logic [1:0]  exp_gnt;
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    idle_all();
    rst_i = 1'b1;

    // Reset state with a live request present.
    @(negedge clk_i);
    set_host(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h5);
    #1;
    check("rst_gnt",     32'(host_gnt_o),    32'h0);
    check("rst_rvalid",  32'(host_rvalid_o), 32'h0);
    check("rst_err",     32'(host_err_o),    32'h0);
    check("rst_rdata",   host_rdata_o,       32'h0);
    check("rst_ram_req", 32'(ram_req_o),     32'h0);
    check("rst_ram_we",  32'(ram_we_o),      32'h0);

    // Idle after release: SRAM port parked at zero.
    @(negedge clk_i);
    idle_all();
    rst_i = 1'b0;
    #1;
    check("idle_ram_req",  32'(ram_req_o),  32'h0);
    check("idle_ram_addr", 32'(ram_addr_o), 32'h0);
    check("idle_ram_be",   32'(ram_be_o),   32'h0);

    // Single read: host0 at 0x10.
    @(negedge clk_i);
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1;
    check("rd_gnt",      32'(host_gnt_o), 32'h1);
    check("rd_ram_req",  32'(ram_req_o),  32'h1);
    check("rd_ram_we",   32'(ram_we_o),   32'h0);
    check("rd_ram_addr", 32'(ram_addr_o), 32'h4);
    @(negedge clk_i);
    idle_all();
    #1;
    check("rd_rvalid", 32'(host_rvalid_o), 32'h1);
    check("rd_err",    32'(host_err_o),    32'h0);
    check("rd_rdata",  host_rdata_o,       32'hDEAD_BEEF);
    check("rd_gnt_idle", 32'(host_gnt_o),  32'h0);

    // Out-of-window read: host0 at 0x10000.
    @(negedge clk_i);
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    #1;
    check("oow_gnt",     32'(host_gnt_o), 32'h1);
    check("oow_ram_req", 32'(ram_req_o),  32'h0);
    @(negedge clk_i);
    idle_all();
    #1;
    check("oow_rvalid", 32'(host_rvalid_o), 32'h1);
    check("oow_err",    32'(host_err_o),    32'h1);
    check("oow_rdata",  host_rdata_o,       32'h0);

    // Byte write: host1 writes 0xAA to 0x20 lane 0, then reads it back.
    @(negedge clk_i);
    set_host(1, 1'b1, 1'b1, 4'b0001, 32'h0000_0020, 32'h0000_00AA);
    #1;
    check("wr_gnt",       32'(host_gnt_o), 32'h2);
    check("wr_ram_req",   32'(ram_req_o),  32'h1);
    check("wr_ram_we",    32'(ram_we_o),   32'h1);
    check("wr_ram_be",    32'(ram_be_o),   32'h1);
    check("wr_ram_addr",  32'(ram_addr_o), 32'h8);
    check("wr_ram_wdata", ram_wdata_o,     32'h0000_00AA);
    @(negedge clk_i);
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    #1;
    check("wr_rvalid",  32'(host_rvalid_o), 32'h2);
    check("wr_err",     32'(host_err_o),    32'h0);
    check("wr_rdata",   host_rdata_o,       32'h0);
    check("rb_gnt",     32'(host_gnt_o),    32'h2);
    check("rb_ram_we",  32'(ram_we_o),      32'h0);
    @(negedge clk_i);
    idle_all();
    #1;
    check("rb_rvalid", 32'(host_rvalid_o), 32'h2);
    check("rb_rdata",  host_rdata_o,       32'h1122_33AA);

    // Contention: both hosts hold requests for four cycles.
    prev_rv = 2'b00;
    prev_rd = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      idle_all();
      set_host(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
      set_host(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      #1;
`ifdef IBEX_SRAM_ARB_ROUND_ROBIN_EN
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      check($sformatf("cont_gnt_%0d", c),    32'(host_gnt_o),    32'(exp_gnt));
      check($sformatf("cont_rvalid_%0d", c), 32'(host_rvalid_o), 32'(prev_rv));
      check($sformatf("cont_rdata_%0d", c),  host_rdata_o,       prev_rd);
      prev_rv = exp_gnt;
      prev_rd = (exp_gnt == 2'b01) ? 32'hA0A0_0000 : 32'hB1B1_0004;
    end
    @(negedge clk_i);
    idle_all();
    #1;
    check("cont_rvalid_4", 32'(host_rvalid_o), 32'(prev_rv));
    check("cont_rdata_4",  host_rdata_o,       prev_rd);

    // Reset mid-response: host1 granted, reset lands on the response cycle.
    @(negedge clk_i);
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    #1;
    check("mrst_gnt", 32'(host_gnt_o), 32'h2);
    @(negedge clk_i);
    rst_i = 1'b1;
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    set_host(1, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0);
    #1;
    check("mrst_rvalid",  32'(host_rvalid_o), 32'h0);
    check("mrst_gnt_rst", 32'(host_gnt_o),    32'h0);
    check("mrst_err",     32'(host_err_o),    32'h0);
    check("mrst_rdata",   host_rdata_o,       32'h0);
    check("mrst_ram_req", 32'(ram_req_o),     32'h0);
    check("mrst_ram_we",  32'(ram_we_o),      32'h0);
    @(negedge clk_i);
    #1;
    check("mrst_rvalid_hold", 32'(host_rvalid_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    #1;
    check("mrst_first_gnt", 32'(host_gnt_o),    32'h1);
    check("mrst_no_rvalid", 32'(host_rvalid_o), 32'h0);
    @(negedge clk_i);
    idle_all();
    #1;
    check("mrst_post_rvalid", 32'(host_rvalid_o), 32'h1);
    check("mrst_post_rdata",  host_rdata_o,       32'hA0A0_0000);

    // Back-to-back reads from host0.
    b2b_addr[0] = 32'h0; b2b_data[0] = 32'hA0A0_0000;
    b2b_addr[1] = 32'h4; b2b_data[1] = 32'hB1B1_0004;
    b2b_addr[2] = 32'h8; b2b_data[2] = 32'hC2C2_0008;
    prev_rv = 2'b00;
    prev_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      idle_all();
      set_host(0, 1'b1, 1'b0, 4'hF, b2b_addr[i], 32'h0);
      #1;
      check($sformatf("b2b_gnt_%0d", i),      32'(host_gnt_o),    32'h1);
      check($sformatf("b2b_ram_addr_%0d", i), 32'(ram_addr_o),    32'(i));
      check($sformatf("b2b_rvalid_%0d", i),   32'(host_rvalid_o), 32'(prev_rv));
      check($sformatf("b2b_rdata_%0d", i),    host_rdata_o,       prev_rd);
      prev_rv = 2'b01;
      prev_rd = b2b_data[i];
    end
    @(negedge clk_i);
    idle_all();
    #1;
    check("b2b_rvalid_3", 32'(host_rvalid_o), 32'h1);
    check("b2b_rdata_3",  host_rdata_o,       32'hC2C2_0008);
    @(negedge clk_i);
    #1;
    check("b2b_rvalid_end", 32'(host_rvalid_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
